tap_bram_arbiter: RTL and testbench
===================================

TAP_BRAM_ARBITER -- requirements
Module: tap_bram_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 12, byte-address width; DATA_W, default 32, word width; NUM_TAPS, default 11, valid word count; STARVE_LIMIT, default 4, max consecutive denied config cycles.
REQ-002 SHALL have ports, clock and reset first: axis_clk in 1, sole clock; axis_rst_n in 1, reset, synchronous, active-low.
REQ-003 SHALL have engine-side ports: eng_req in 1, read request; eng_addr in ADDR_W, byte address; eng_gnt out 1, granted this cycle; eng_rvalid out 1, read data valid; eng_rdata out DATA_W, read data.
REQ-004 SHALL have config-side ports: cfg_req in 1; cfg_we in 1, 1=write; cfg_wstrb in 4, byte enables; cfg_addr in ADDR_W; cfg_wdata in DATA_W; cfg_gnt out 1; cfg_rvalid out 1; cfg_rdata out DATA_W; cfg_err out 1, one-cycle error pulse.
REQ-005 SHALL have ports: eng_busy in 1, FIR engine running; tap_EN out 1; tap_WE out 4; tap_A out ADDR_W; tap_Di out DATA_W; tap_Do in DATA_W, driven by the tap RAM, which registers address on axis_clk, returns data the next cycle and gates it with tap_EN.

Function
REQ-006 SHALL arbitrate each cycle combinationally; a grant means the request is issued to tap_* in that same cycle.
REQ-007 SHALL give eng_req priority over cfg_req when both are asserted, except per REQ-019.
REQ-008 SHALL hold a requester ungranted with no side effect; the requester keeps req, addr and data stable until gnt.
REQ-009 SHALL, on grant, drive tap_A from the winner's address; on a config write also drive tap_Di=cfg_wdata and tap_WE=cfg_wstrb; otherwise tap_WE=0.
REQ-010 SHALL assert eng_rvalid or cfg_rvalid exactly one cycle after the owner's read grant, with rdata=tap_Do in that cycle.
REQ-011 SHALL drive tap_EN=1 in any grant cycle and in any cycle where a read response is returning; otherwise 0.
REQ-012 SHALL support back-to-back grants every cycle, including alternating owners; the response pipeline is one entry deep per cycle.
REQ-013 SHALL treat an address with (addr>>2) >= NUM_TAPS as out of range: the request is still granted; writes are issued with tap_WE=0; reads return rdata=0 with rvalid as normal; cfg_err pulses one cycle after a config out-of-range grant. Engine out-of-range reads are not flagged.
REQ-014 SHALL, for a config write while eng_busy=1, grant it, force tap_WE=0 and pulse cfg_err the next cycle. Config reads while busy are legal.
REQ-015 SHALL return new data for a read granted the cycle after a write to the same word.
REQ-016 SHALL hold eng_rdata and cfg_rdata at their last value when the matching rvalid is 0.

Reset
REQ-017 SHALL, while axis_rst_n=0 at a clock edge, clear eng_rvalid, cfg_rvalid and cfg_err to 0, eng_rdata and cfg_rdata to 0, and the starvation counter to 0; a read response in flight is discarded.
REQ-018 SHALL suppress all grants while axis_rst_n=0: eng_gnt=cfg_gnt=0, tap_EN=0, tap_WE=0.

Configuration
REQ-019 SHALL, with macro TAP_ARB_STARVE_GUARD_EN defined, count consecutive cycles with cfg_req=1 and cfg_gnt=0. When the count equals STARVE_LIMIT, config wins the next contended cycle and the count clears. Any config grant also clears the count.
REQ-020 SHALL, without TAP_ARB_STARVE_GUARD_EN, use strict engine priority; no counter logic is present.

Verification
REQ-021 Reset: axis_rst_n=0 for 2 cycles with eng_req=cfg_req=1 -> both gnt=0, tap_EN=0, all rvalid/rdata/err=0.
REQ-022 Config write cfg_addr=0x08, wdata=0xDEADBEEF, wstrb=0xF, eng_busy=0; then config read 0x08 -> tap_WE=0xF on the write cycle; cfg_rvalid=1 one cycle after the read grant with cfg_rdata=0xDEADBEEF.
REQ-023 eng_req and cfg_req both held, eng_addr 0x00..0x28 -> eng_gnt every cycle; with guard on, cfg_gnt on the 5th cycle (STARVE_LIMIT=4); with guard off, cfg_gnt only after eng_req drops.
REQ-024 Config write 0x2C (word 11) -> tap_WE=0, cfg_err pulses; config read 0x2C -> cfg_rdata=0.
REQ-025 eng_busy=1 and config write 0x04 -> granted, tap_WE=0, cfg_err=1 next cycle, word 1 unchanged on readback.
REQ-026 Engine read granted, then axis_rst_n=0 on the following edge -> eng_rvalid stays 0.

Source files
------------

// File: rtl/tap_bram_arbiter.sv
// Two-port arbiter: FIR engine and config bus share one tap RAM.
// Ports: axis_clk/axis_rst_n; eng_* (read-only port); cfg_* (read/write
// port with cfg_err pulse); eng_busy; tap_* to the single-port tap RAM.
// Optional macro TAP_ARB_STARVE_GUARD_EN: bounded config starvation.
module tap_bram_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int NUM_TAPS     = 11,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic              eng_req,
  input  logic [ADDR_W-1:0] eng_addr,
  output logic              eng_gnt,
  output logic              eng_rvalid,
  output logic [DATA_W-1:0] eng_rdata,
  input  logic              cfg_req,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_wstrb,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              cfg_gnt,
  output logic              cfg_rvalid,
  output logic [DATA_W-1:0] cfg_rdata,
  output logic              cfg_err,
  input  logic              eng_busy,
  output logic              tap_EN,
  output logic [3:0]        tap_WE,
  output logic [ADDR_W-1:0] tap_A,
  output logic [DATA_W-1:0] tap_Di,
  input  logic [DATA_W-1:0] tap_Do
);

  localparam logic [ADDR_W-1:0] LP_NT = ADDR_W'(NUM_TAPS);

  logic              w_cfg_pri;
  logic              w_eng_gnt;
  logic              w_cfg_gnt;
  logic              w_any_gnt;
  logic [ADDR_W-1:0] w_addr;
  logic              w_oor;
  logic              w_wr;
  logic              w_wr_bad;
  logic [DATA_W-1:0] w_rd_data;

  logic              r_eng_pend;
  logic              r_cfg_pend;
  logic              r_rd_oor;
  logic              r_cfg_err;
  logic [DATA_W-1:0] r_eng_rdata;
  logic [DATA_W-1:0] r_cfg_rdata;

`ifdef TAP_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 2);
  localparam logic [CW-1:0] LP_LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_starve;

  // Config overrides engine priority once it has waited long enough.
  assign w_cfg_pri = (r_starve == LP_LIM);

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      r_starve <= '0;
    end else if (w_cfg_gnt || !cfg_req) begin
      r_starve <= '0;
    end else if (r_starve != LP_LIM) begin
      r_starve <= r_starve + 1'b1;
    end
  end
`else
  assign w_cfg_pri = 1'b0;
`endif

  assign w_eng_gnt = axis_rst_n & eng_req
                   & ~(cfg_req & w_cfg_pri);
  assign w_cfg_gnt = axis_rst_n & cfg_req
                   & (~eng_req | w_cfg_pri);
  assign w_any_gnt = w_eng_gnt | w_cfg_gnt;

  assign w_addr = w_eng_gnt ? eng_addr : cfg_addr;
  // Word index compare; low two address bits select a byte.
  assign w_oor  = {2'b00, w_addr[ADDR_W-1:2]} >= LP_NT;

  assign w_wr     = w_cfg_gnt & cfg_we;
  assign w_wr_bad = w_wr & eng_busy;

  assign eng_gnt = w_eng_gnt;
  assign cfg_gnt = w_cfg_gnt;

  assign tap_A  = w_any_gnt ? w_addr : '0;
  assign tap_Di = w_wr ? cfg_wdata : '0;
  // Rejected writes still consume the slot but never touch the RAM.
  assign tap_WE = (w_wr & ~w_oor & ~eng_busy) ? cfg_wstrb : 4'h0;
  assign tap_EN = w_any_gnt | r_eng_pend | r_cfg_pend;

  assign w_rd_data = r_rd_oor ? '0 : tap_Do;

  assign eng_rvalid = r_eng_pend;
  assign cfg_rvalid = r_cfg_pend;
  assign cfg_err    = r_cfg_err;
  assign eng_rdata  = r_eng_pend ? w_rd_data : r_eng_rdata;
  assign cfg_rdata  = r_cfg_pend ? w_rd_data : r_cfg_rdata;

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      r_eng_pend  <= 1'b0;
      r_cfg_pend  <= 1'b0;
      r_rd_oor    <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_eng_rdata <= '0;
      r_cfg_rdata <= '0;
    end else begin
      r_eng_pend <= w_eng_gnt;
      r_cfg_pend <= w_cfg_gnt & ~cfg_we;
      r_rd_oor   <= w_oor;
      r_cfg_err  <= w_cfg_gnt & (w_oor | w_wr_bad);
      if (r_eng_pend) r_eng_rdata <= w_rd_data;
      if (r_cfg_pend) r_cfg_rdata <= w_rd_data;
    end
  end

endmodule

// File: tb/tb_tap_bram_arbiter.sv
// Bench for tap_bram_arbiter: tap RAM behavioural model plus a
// spec-level reference of tap contents, priority and responses.
module tb_tap_bram_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NT = 11;
  localparam int SL = 4;
`ifdef TAP_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          eng_req;
  logic [AW-1:0] eng_addr;
  logic          eng_gnt;
  logic          eng_rvalid;
  logic [DW-1:0] eng_rdata;
  logic          cfg_req;
  logic          cfg_we;
  logic [3:0]    cfg_wstrb;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_wdata;
  logic          cfg_gnt;
  logic          cfg_rvalid;
  logic [DW-1:0] cfg_rdata;
  logic          cfg_err;
  logic          eng_busy;
  logic          tap_EN;
  logic [3:0]    tap_WE;
  logic [AW-1:0] tap_A;
  logic [DW-1:0] tap_Di;
  logic [DW-1:0] tap_Do;

  tap_bram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .NUM_TAPS(NT), .STARVE_LIMIT(SL)
  ) dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .eng_req(eng_req), .eng_addr(eng_addr),
    .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid),
    .eng_rdata(eng_rdata),
    .cfg_req(cfg_req), .cfg_we(cfg_we),
    .cfg_wstrb(cfg_wstrb), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_gnt(cfg_gnt),
    .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata),
    .cfg_err(cfg_err), .eng_busy(eng_busy),
    .tap_EN(tap_EN), .tap_WE(tap_WE), .tap_A(tap_A),
    .tap_Di(tap_Di), .tap_Do(tap_Do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(
    input logic [31:0] old, input logic [31:0] nw,
    input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (st[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Physical tap RAM: registered address, output gated by tap_EN.
  logic [31:0] ram [0:1023];
  logic [9:0]  ram_a;
  always @(posedge clk) begin
    if (tap_EN) begin
      ram[tap_A[11:2]] <= merge(ram[tap_A[11:2]], tap_Di, tap_WE);
      ram_a <= tap_A[11:2];
    end
  end
  assign tap_Do = tap_EN ? ram[ram_a] : '0;

  // Reference model state
  logic [31:0] ref_mem [0:NT-1];
  int          starve;
  bit          pend_prev;
  logic [31:0] last_e;
  logic [31:0] last_c;
  int          checks;
  int          errors;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    starve    = 0;
    pend_prev = 1'b0;
    last_e    = '0;
    last_c    = '0;
  endtask

  // One arbitration cycle: drive, check grant-cycle outputs, then
  // check the response cycle against the reference model.
  task automatic cyc(
    input bit er, input logic [AW-1:0] ea,
    input bit cr, input bit cw, input logic [3:0] st,
    input logic [AW-1:0] ca, input logic [31:0] wd,
    input bit bz, output bit eg, output bit cg);
    bit          cwin;
    bit          ewin;
    bit          oor;
    bit          ev;
    bit          cv;
    bit          err;
    int          idx;
    logic [AW-1:0] a;
    logic [3:0]  xwe;
    logic [31:0] rd;
    eng_req   = er;
    eng_addr  = ea;
    cfg_req   = cr;
    cfg_we    = cw;
    cfg_wstrb = st;
    cfg_addr  = ca;
    cfg_wdata = wd;
    eng_busy  = bz;
    #2;
    cwin = cr && (!er || (GUARD && starve == SL));
    ewin = er && !cwin;
    chk("eng_gnt", eng_gnt, ewin);
    chk("cfg_gnt", cfg_gnt, cwin);
    chk("tap_EN", tap_EN, ewin || cwin || pend_prev);
    a   = ewin ? ea : ca;
    idx = int'(a >> 2);
    oor = idx >= NT;
    if (ewin || cwin) chk("tap_A", tap_A, a);
    xwe = (cwin && cw && !oor && !bz) ? st : 4'h0;
    chk("tap_WE", tap_WE, xwe);
    if (cwin && cw) chk("tap_Di", tap_Di, wd);
    rd  = oor ? 32'h0 : ref_mem[oor ? 0 : idx];
    ev  = ewin;
    cv  = cwin && !cw;
    err = cwin && (oor || (cw && bz));
    if (xwe != 4'h0) ref_mem[idx] = merge(ref_mem[idx], wd, st);
    if (cwin || !cr) starve = 0;
    else if (starve < SL) starve++;
    pend_prev = ev || cv;
    @(posedge clk); #1;
    chk("eng_rvalid", eng_rvalid, ev);
    chk("cfg_rvalid", cfg_rvalid, cv);
    chk("cfg_err", cfg_err, err);
    if (ev) last_e = rd;
    if (cv) last_c = rd;
    chk("eng_rdata", eng_rdata, last_e);
    chk("cfg_rdata", cfg_rdata, last_c);
    eg = ewin;
    cg = cwin;
  endtask

  bit            eg;
  bit            cg;
  int            first;
  bit            r_er;
  bit            r_cr;
  bit            r_cw;
  bit            r_bz;
  logic [3:0]    r_st;
  logic [AW-1:0] r_ea;
  logic [AW-1:0] r_ca;
  logic [31:0]   r_wd;

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    rst_n     = 1'b0;
    eng_req   = 1'b1;
    eng_addr  = '0;
    cfg_req   = 1'b1;
    cfg_we    = 1'b0;
    cfg_wstrb = 4'h0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    eng_busy  = 1'b0;

    // Reset with both requesters asserted
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("rst_eng_gnt", eng_gnt, 1'b0);
      chk("rst_cfg_gnt", cfg_gnt, 1'b0);
      chk("rst_tap_EN", tap_EN, 1'b0);
      chk("rst_tap_WE", tap_WE, 4'h0);
      @(posedge clk); #1;
      chk("rst_eng_rvalid", eng_rvalid, 1'b0);
      chk("rst_cfg_rvalid", cfg_rvalid, 1'b0);
      chk("rst_cfg_err", cfg_err, 1'b0);
      chk("rst_eng_rdata", eng_rdata, 32'h0);
      chk("rst_cfg_rdata", cfg_rdata, 32'h0);
    end
    rst_n = 1'b1;

    // Preload every tap word
    for (int i = 0; i < NT; i++)
      cyc(0, '0, 1, 1, 4'hF, AW'(i << 2), $urandom, 0, eg, cg);

    // Write then read back word 2
    cyc(0, '0, 1, 1, 4'hF, 12'h008, 32'hDEADBEEF, 0, eg, cg);
    cyc(0, '0, 1, 0, 4'h0, 12'h008, 32'h0, 0, eg, cg);
    chk("rd_0x08", cfg_rdata, 32'hDEADBEEF);

    // Partial byte write, read back by engine the next cycle
    cyc(0, '0, 1, 1, 4'h3, 12'h008, 32'h00001234, 0, eg, cg);
    cyc(1, 12'h008, 0, 0, 4'h0, '0, 32'h0, 0, eg, cg);
    chk("rd_partial", eng_rdata, 32'hDEAD1234);

    // Out-of-range word 11
    cyc(0, '0, 1, 1, 4'hF, 12'h02C, 32'hCAFEF00D, 0, eg, cg);
    chk("oor_wr_err", cfg_err, 1'b1);
    cyc(0, '0, 1, 0, 4'h0, 12'h02C, 32'h0, 0, eg, cg);
    chk("oor_rd_zero", cfg_rdata, 32'h0);
    cyc(1, 12'h3FC, 0, 0, 4'h0, '0, 32'h0, 0, eg, cg);

    // Config write while engine busy is dropped
    cyc(0, '0, 1, 1, 4'hF, 12'h004, 32'h12345678, 1, eg, cg);
    chk("busy_wr_err", cfg_err, 1'b1);
    cyc(0, '0, 1, 0, 4'h0, 12'h004, 32'h0, 1, eg, cg);
    chk("busy_rd_unchanged", cfg_rdata === 32'h12345678, 1'b0);

    // Contention: engine sweeps all taps, config waits
    first = -1;
    for (int i = 0; i < NT; i++) begin
      cyc(1, AW'(i << 2), 1, 0, 4'h0, 12'h014, 32'h0, 0, eg, cg);
      if (cg && first < 0) first = i;
    end
    chk("starve_first_cfg", 64'(first), GUARD ? 64'(SL) : 64'hFFFF_FFFF_FFFF_FFFF);
    cyc(0, '0, 1, 0, 4'h0, 12'h014, 32'h0, 0, eg, cg);
    chk("cfg_after_eng_drop", cg, 1'b1);

    // Alternating owners back to back, write-then-read same word
    for (int i = 0; i < 6; i++) begin
      cyc(0, '0, 1, 1, 4'hF, AW'(i << 2), 32'hA5000000 + i, 0, eg, cg);
      cyc(1, AW'(i << 2), 0, 0, 4'h0, '0, 32'h0, 0, eg, cg);
    end

    // Reset while an engine read response is in flight
    eng_req  = 1'b1;
    eng_addr = 12'h010;
    cfg_req  = 1'b0;
    #2;
    chk("flight_gnt", eng_gnt, 1'b1);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("flight_rvalid", eng_rvalid, 1'b0);
    chk("flight_rdata", eng_rdata, 32'h0);
    eng_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // Randomized traffic; requesters hold until granted
    r_er = 0;
    r_cr = 0;
    r_ea = '0;
    r_ca = '0;
    r_cw = 0;
    r_st = 4'h0;
    r_wd = '0;
    eg = 0;
    cg = 0;
    for (int n = 0; n < 400; n++) begin
      if (!r_er || eg) begin
        r_er = 1'($urandom_range(0, 1));
        r_ea = AW'($urandom_range(0, 15) << 2);
      end
      if (!r_cr || cg) begin
        r_cr = 1'($urandom_range(0, 1));
        r_cw = 1'($urandom_range(0, 1));
        r_st = 4'($urandom_range(0, 15));
        r_ca = AW'($urandom_range(0, 15) << 2);
        r_wd = $urandom;
      end
      r_bz = ($urandom_range(0, 3) == 0);
      cyc(r_er, r_ea, r_cr, r_cw, r_st, r_ca, r_wd, r_bz, eg, cg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
